// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR constants used by the output FIFO slice
package fir_pkg;

    localparam int FIR_DATA_W      = 32;
    localparam int FIR_LEN_W       = 32;
    localparam int FIR_OFIFO_DEPTH = 16;

    // Register offset holding the programmed frame length
    localparam logic [11:0] FIR_REG_DATA_LEN = 12'h10;

endpackage

// File: rtl/fir_frame_chk.sv
// rtl/fir_frame_chk.sv - frame length checker and completion pulse for the output FIFO
module fir_frame_chk
    import fir_pkg::*;
#(
    parameter int pLEN_WIDTH = FIR_LEN_W
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    input  logic                  push,
    input  logic                  push_last,
    input  logic                  pop,
    input  logic                  pop_last,
    input  logic [pLEN_WIDTH-1:0] data_length,
    input  logic                  err_clr,
    output logic                  frame_done,
    output logic                  len_err
);

    logic [pLEN_WIDTH-1:0] beat_cnt;
    logic [pLEN_WIDTH-1:0] beat_nxt;
    logic                  len_hit;
    logic                  err_evt;

    // The beat being pushed is number beat_cnt+1 of the current frame
    assign beat_nxt = beat_cnt + pLEN_WIDTH'(1);
    assign len_hit  = (beat_nxt == data_length);
    // Early tlast, or the programmed length reached without tlast
    assign err_evt  = push && (push_last ? !len_hit : len_hit);

    // Beat counter restarts after every tlast beat entering the FIFO
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            beat_cnt <= '0;
        end else if (push) begin
            beat_cnt <= push_last ? '0 : beat_nxt;
        end
    end

    // Sticky error; a new error in the same cycle beats the clear
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            len_err <= 1'b0;
        end else if (err_evt) begin
            len_err <= 1'b1;
        end else if (err_clr) begin
            len_err <= 1'b0;
        end
    end

    // Completion pulse the cycle after the last beat leaves the FIFO
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && pop_last;
        end
    end

endmodule

// File: rtl/fir_sm_fifo.sv
// rtl/fir_sm_fifo.sv - output-side stream buffer with frame length checking
module fir_sm_fifo
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = FIR_DATA_W,
    parameter int pDEPTH      = FIR_OFIFO_DEPTH,
    parameter int pLEN_WIDTH  = FIR_LEN_W
) (
    input  logic                       axis_clk,
    input  logic                       axis_rst_n,
    input  logic                       s_tvalid,
    input  logic [pDATA_WIDTH-1:0]     s_tdata,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic                       m_tvalid,
    output logic [pDATA_WIDTH-1:0]     m_tdata,
    output logic                       m_tlast,
    input  logic                       m_tready,
    input  logic [pLEN_WIDTH-1:0]      data_length,
    input  logic                       err_clr,
    output logic [$clog2(pDEPTH):0]    level,
    output logic                       frame_done,
    output logic                       len_err
);

    localparam int            AW       = $clog2(pDEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(pDEPTH);
    localparam logic [AW:0]   ONE      = (AW+1)'(1);

    logic [pDATA_WIDTH:0] mem [pDEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW:0]          level_nxt;
    logic [pDATA_WIDTH:0] head;
    logic                 push;
    logic                 pop;

    assign push     = s_tvalid && s_tready;
    // Extra pointer MSB tells full from empty when the low bits match
    assign m_tvalid = (wr_ptr != rd_ptr);
    assign pop      = m_tvalid && m_tready;

    // First-word fall-through; outputs read as zero while empty
    assign head    = mem[rd_ptr[AW-1:0]];
    assign m_tdata = m_tvalid ? head[pDATA_WIDTH-1:0] : '0;
    assign m_tlast = m_tvalid && head[pDATA_WIDTH];

    // Occupancy after this cycle's push/pop
    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + ONE;
            2'b01:   level_nxt = level - ONE;
            default: level_nxt = level;
        endcase
    end

    // Storage needs no reset: contents are only visible while valid
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
        end
    end

    // Pointers, level and a registered ready so m_tready never reaches s_tready
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            s_tready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
            level    <= level_nxt;
            s_tready <= (level_nxt != FULL_LVL);
        end
    end

    fir_frame_chk #(
        .pLEN_WIDTH (pLEN_WIDTH)
    ) u_frame_chk (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .push        (push),
        .push_last   (s_tlast),
        .pop         (pop),
        .pop_last    (m_tlast),
        .data_length (data_length),
        .err_clr     (err_clr),
        .frame_done  (frame_done),
        .len_err     (len_err)
    );

endmodule

// File: tb/tb_fir_sm_fifo.sv
// tb/tb_fir_sm_fifo.sv - self-checking bench for the FIR output FIFO
module tb_fir_sm_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic [31:0] data_length;
    logic        err_clr;
    logic [4:0]  level;
    logic        frame_done;
    logic        len_err;

    int tests = 0;
    int fails = 0;

    fir_sm_fifo dut (
        .axis_clk    (clk),
        .axis_rst_n  (rst_n),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tvalid    (m_tvalid),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .data_length (data_length),
        .err_clr     (err_clr),
        .level       (level),
        .frame_done  (frame_done),
        .len_err     (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a bounded queue plus frame bookkeeping
    logic [32:0] mq[$];
    logic [31:0] m_cnt;
    logic        exp_err;
    logic        exp_done;
    logic [32:0] m_tmp;
    bit          m_push, m_pop, m_last;

    initial begin
        mq.delete();
        m_cnt = 0; exp_err = 0; exp_done = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_cnt = 0; exp_err = 0; exp_done = 0;
            end else begin
                m_push = s_tvalid && (mq.size() < 16);
                m_pop  = (mq.size() != 0) && m_tready;
                m_last = 0;
                if (m_pop) begin
                    m_tmp  = mq.pop_front();
                    m_last = m_tmp[32];
                end
                exp_done = m_pop && m_last;
                if (m_push) begin
                    if (s_tlast) begin
                        if (m_cnt + 32'd1 != data_length) exp_err = 1;
                        else if (err_clr) exp_err = 0;
                        m_cnt = 0;
                    end else begin
                        if (m_cnt + 32'd1 == data_length) exp_err = 1;
                        else if (err_clr) exp_err = 0;
                        m_cnt = m_cnt + 32'd1;
                    end
                end else if (err_clr) begin
                    exp_err = 0;
                end
                if (m_push) mq.push_back({s_tlast, s_tdata});
            end
        end
    end

    // Compare DUT against the model every cycle, plus stall stability
    int          done_cnt = 0;
    int          max_level = 0;
    bit          stalled = 0;
    logic [32:0] stall_word;

    always @(negedge clk) begin
        check("s_tready", s_tready, mq.size() < 16);
        check("m_tvalid", m_tvalid, mq.size() != 0);
        check("level", level, mq.size());
        if (mq.size() != 0) begin
            check("m_tdata", m_tdata, mq[0][31:0]);
            check("m_tlast", m_tlast, mq[0][32]);
        end
        check("frame_done", frame_done, exp_done);
        check("len_err", len_err, exp_err);
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_word", {m_tlast, m_tdata}, stall_word);
            end
            stalled    = m_tvalid && !m_tready;
            stall_word = {m_tlast, m_tdata};
        end
        if (frame_done) done_cnt++;
        if (int'(level) > max_level) max_level = int'(level);
    end

    // Stimulus source
    logic [32:0] src[$];
    logic [32:0] s_tmp;

    task automatic drive(input int vp, input int rp, input int maxc, input bit drain);
        int  c = 0;
        bit  rdy;
        while (c < maxc && (src.size() != 0 || (drain && mq.size() != 0))) begin
            s_tvalid = (src.size() != 0) && ($urandom_range(99) < vp);
            if (src.size() != 0) {s_tlast, s_tdata} = src[0];
            m_tready = ($urandom_range(99) < rp);
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            if (s_tvalid && rdy) s_tmp = src.pop_front();
            #1;
            c++;
        end
        s_tvalid = 0;
        s_tlast  = 0;
        if (drain) check("drain_left", src.size() + mq.size(), 0);
    endtask

    task automatic frame(input int n, input int last_at, input logic [31:0] base);
        for (int i = 1; i <= n; i++)
            src.push_back({(i == last_at), base + 32'(i)});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int d0;

    initial begin
        rst_n = 0; s_tvalid = 0; s_tdata = 0; s_tlast = 0;
        m_tready = 0; data_length = 600; err_clr = 0;
        cycles(2);
        @(negedge clk);
        check("rst_s_tready", s_tready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_level", level, 0);
        check("rst_len_err", len_err, 0);
        @(posedge clk); #1;
        rst_n = 1;
        cycles(1);

        // 600-beat signed ramp from -300, latency of first beat
        d0 = done_cnt;
        s_tvalid = 1; s_tdata = 32'hFFFF_FED4; s_tlast = 0; m_tready = 0;
        @(negedge clk);
        check("lat_before", m_tvalid, 0);
        @(posedge clk); #1;
        s_tvalid = 0;
        @(negedge clk);
        check("lat_valid", m_tvalid, 1);
        check("lat_data", m_tdata, 64'h0000_0000_FFFF_FED4);
        @(posedge clk); #1;
        frame(599, 599, 32'hFFFF_FED4);
        drive(100, 100, 2000, 1);
        cycles(2);
        check("ramp_done_cnt", done_cnt - d0, 1);
        check("ramp_len_err", len_err, 0);

        // Fill with consumer stalled, then drain
        data_length = 20;
        d0 = done_cnt;
        frame(20, 20, 32'd1000);
        drive(100, 0, 25, 0);
        @(negedge clk);
        check("fill_level", level, 16);
        check("fill_s_tready", s_tready, 0);
        @(posedge clk); #1;
        drive(100, 100, 200, 1);
        cycles(2);
        check("fill_done_cnt", done_cnt - d0, 1);
        check("fill_len_err", len_err, 0);

        // Random traffic, 5000-beat frame
        data_length = 5000;
        d0 = done_cnt;
        for (int i = 1; i <= 5000; i++) src.push_back({(i == 5000), 32'($urandom)});
        drive(70, 50, 40000, 1);
        cycles(2);
        check("rand_max_level", max_level <= 16, 1);
        check("rand_done_cnt", done_cnt - d0, 1);
        check("rand_len_err", len_err, 0);

        // Early tlast on beat 6 of 8, then clear, then a good frame
        data_length = 8;
        frame(6, 6, 32'd200);
        drive(100, 100, 100, 1);
        cycles(1);
        check("early_len_err", len_err, 1);
        err_clr = 1;
        cycles(1);
        err_clr = 0;
        @(negedge clk);
        check("clr_len_err", len_err, 0);
        @(posedge clk); #1;
        frame(8, 8, 32'd300);
        drive(100, 100, 100, 1);
        cycles(1);
        check("good_len_err", len_err, 0);

        // Missing tlast at beat 8, tlast on beat 10
        frame(10, 10, 32'd400);
        drive(100, 100, 100, 1);
        cycles(1);
        check("late_len_err", len_err, 1);
        err_clr = 1;
        cycles(1);
        err_clr = 0;

        // Reset with 10 entries buffered mid-frame
        frame(20, 20, 32'd500);
        drive(100, 0, 10, 0);
        @(negedge clk);
        check("pre_rst_level", level, 10);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("arst_level", level, 0);
        check("arst_m_tvalid", m_tvalid, 0);
        check("arst_m_tdata", m_tdata, 0);
        check("arst_s_tready", s_tready, 1);
        check("arst_len_err", len_err, 0);
        check("arst_frame_done", frame_done, 0);
        src.delete();
        @(posedge clk); #1;
        rst_n = 1;
        cycles(1);
        d0 = done_cnt;
        frame(8, 8, 32'd600);
        drive(100, 100, 100, 1);
        cycles(2);
        check("post_rst_len_err", len_err, 0);
        check("post_rst_done_cnt", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_sm_fifo.md
# fir_sm_fifo

Output-side AXI-Stream buffer placed directly downstream of the FIR core's `sm_*` master port. It absorbs FIR results when the consumer stalls, so a slow or bursty reader does not stall the FIR pipeline on every sample. It also checks each frame's length against the programmed data length (the same value written to FIR register 0x10) and reports frame completion and length errors.

## Interface
- `pDATA_WIDTH`, 32, stream data width.
- `pDEPTH`, 16, FIFO entries; must be a power of 2 and at least 2.
- `pLEN_WIDTH`, 32, width of the frame-length and beat counters.

Ports:
- `axis_clk`  in  1  single clock.
- `axis_rst_n`  in  1  asynchronous, active-low reset.
- `s_tvalid`  in  1  from FIR `sm_tvalid`.
- `s_tdata`  in  pDATA_WIDTH  from FIR `sm_tdata`; signed.
- `s_tlast`  in  1  from FIR `sm_tlast`.
- `s_tready`  out  1  to FIR `sm_tready`.
- `m_tvalid`  out  1  to consumer.
- `m_tdata`  out  pDATA_WIDTH  to consumer.
- `m_tlast`  out  1  to consumer.
- `m_tready`  in  1  from consumer.
- `data_length`  in  pLEN_WIDTH  expected beats per frame; sampled on every input beat.
- `err_clr`  in  1  synchronous clear of `len_err`.
- `level`  out  $clog2(pDEPTH)+1  current occupancy, 0..pDEPTH.
- `frame_done`  out  1  one-cycle pulse.
- `len_err`  out  1  sticky frame-length error flag.

## Operation
- Storage is a flop array of {tlast, tdata}. Read and write pointers are $clog2(pDEPTH)+1 bits wide; the MSB distinguishes full from empty, and the pointers wrap naturally.
- Push occurs when `s_tvalid && s_tready`. Pop occurs when `m_tvalid && m_tready`.
- `s_tready` = !full, registered from the next-state level.
- `m_tvalid` = !empty. `m_tdata` and `m_tlast` come combinationally from the entry at the read pointer; this is first-word fall-through off registered storage.
- Push and pop in the same cycle: both take effect and `level` is unchanged.
- When full, `s_tready`=0, even if a pop happens that cycle. There is no full-bypass, so `s_tready` has no combinational path from `m_tready`.
- When empty, there is no write-through to the output; a push becomes visible on the next cycle.
- Beat counter `beat_cnt` increments on each push.
- Push with `s_tlast`=1:
  - If `beat_cnt`+1 != `data_length`, set `len_err`.
  - `beat_cnt` returns to 0.
- Push with `s_tlast`=0 and `beat_cnt`+1 == `data_length`: set `len_err` (the tlast is missing). The counter keeps counting until a tlast arrives.
- `frame_done` pulses for one cycle, the cycle after a pop whose `m_tlast`=1.
- `len_err` stays set until `err_clr`=1 or reset.
- If `err_clr` and a new error occur in the same cycle, the error wins and `len_err` stays 1.
- `data_length`=0: every tlast beat flags an error.

## Timing
- Reset values: `s_tready`=1, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `level`=0, `frame_done`=0, `len_err`=0, pointers=0, `beat_cnt`=0.
- Latency from input push to `m_tvalid`: 1 cycle when the FIFO is empty.
- Sustained throughput: 1 beat per cycle with `m_tready` held high.
- After the FIFO fills, `s_tready` deasserts in the cycle after the push that filled it. It reasserts the cycle after the first pop.
- `level` is registered and updates the cycle after a push or pop.
- Reset asserted mid-frame: all state clears immediately and asynchronously; buffered data is discarded. The first beat after reset starts a new frame count.
- Handshake rules: AXI-Stream compliant. `m_tvalid` never drops without a pop, and `m_tdata`/`m_tlast` are stable while `m_tvalid && !m_tready`.

## Structure
- Shared package `fir_pkg`:
  - `FIR_DATA_W`=32
  - `FIR_LEN_W`=32
  - `FIR_OFIFO_DEPTH`=16
  - register offset constant `FIR_REG_DATA_LEN`=12'h10
- One sub-module, `fir_frame_chk`: contains the beat counter, the `len_err` logic and the `frame_done` logic. It sees only the push/pop strobes and tlast.
- The FIFO storage and pointer logic stay in the top module. Expected RTL size is about 180 lines.

## Test plan
- Length 600, signed ramp from -300, `m_tready`=1, tlast on beat 600 → all 600 beats out in order. `frame_done` pulses once, one cycle after beat 600 pops. `len_err`=0. Latency from first push to first `m_tvalid` is 1 cycle.
- `m_tready`=0 and 20 beats offered → 16 accepted, `level`=16, `s_tready`=0 from the cycle after the 16th push. Then `m_tready`=1 → `s_tready`=1 one cycle after the first pop, and all 20 beats arrive in order.
- Random `m_tready` at 50% and random `s_tvalid` at 70%, 5000 beats → scoreboard matches exactly. `level` never exceeds 16. `m_tdata` is stable during stalls.
- `data_length`=8 with tlast on beat 6 → `len_err`=1 the cycle after beat 6. Then `err_clr` → 0. A following 8-beat frame leaves `len_err`=0.
- `data_length`=8 with no tlast on beat 8 and tlast on beat 10 → `len_err` set after beat 8.
- Reset with 10 entries buffered, mid-frame → outputs go to their reset values immediately, `level`=0. A following 8-beat frame passes with no error.
